// File: rtl/bus_a_sequencer_pkg.sv
// Shared encodings for the bus-A sequencer: select codes, opcodes, ALU ops, FSM states.
// Also holds the state-to-control decode used for the registered outputs.
package bus_a_sequencer_pkg;

  localparam logic [2:0] SEL_AC   = 3'd0;
  localparam logic [2:0] SEL_AR   = 3'd1;
  localparam logic [2:0] SEL_PC   = 3'd2;
  localparam logic [2:0] SEL_DR   = 3'd3;
  localparam logic [2:0] SEL_TR   = 3'd4;
  localparam logic [2:0] SEL_ZERO = 3'd5;
  localparam logic [2:0] SEL_END  = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_MOVT = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;

  typedef enum logic [3:0] {
    StIdle, StF1, StF2, StDec, StAdr, StMr, StEx, StMw, StJmp, StMvt, StEnd, StFault
  } state_e;

  typedef struct packed {
    logic [2:0] sel;
    logic       ld_ac;
    logic       ld_ar;
    logic       ld_pc;
    logic       ld_tr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] alu_op;
    logic       halted;
    logic       fault;
  } ctrl_t;

  // Moore decode; ld_dr and inc_pc are excluded because they depend on mem_ready.
  function automatic ctrl_t decode_ctrl(input state_e s, input logic [3:0] op);
    ctrl_t c;
    c        = '0;
    c.sel    = SEL_ZERO;
    c.alu_op = ALU_PASS;
    unique case (s)
      StF1:    begin c.sel = SEL_PC;  c.ld_ar  = 1'b1; end
      StF2:    begin c.sel = SEL_AR;  c.mem_rd = 1'b1; end
      StAdr:   begin c.sel = SEL_DR;  c.ld_ar  = 1'b1; end
      StMr:    begin c.sel = SEL_AR;  c.mem_rd = 1'b1; end
      StEx: begin
        c.sel    = SEL_DR;
        c.ld_ac  = 1'b1;
        c.alu_op = (op == OP_ADD) ? ALU_ADD : ALU_PASS;
      end
      StMw:    begin c.sel = SEL_AC;  c.mem_wr = 1'b1; end
      StJmp:   begin c.sel = SEL_DR;  c.ld_pc  = 1'b1; end
      StMvt:   begin c.sel = SEL_AC;  c.ld_tr  = 1'b1; end
      StEnd:   begin c.sel = SEL_END; c.halted = 1'b1; end
      StFault: begin c.sel = SEL_END; c.fault  = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bus_a_sequencer_mem_wait_timer.sv
// Counts cycles a memory request has waited; flags timeout on the last allowed cycle.
module bus_a_sequencer_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  logic [7:0] cnt_q, cnt_d;

  // Held at zero outside wait states, so every wait state starts from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i) begin
      cnt_d = '0;
    end else if (!mem_ready_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign timeout_o = active_i && !mem_ready_i && (cnt_q == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_a_sequencer.sv
// Fetch/decode/execute control FSM driving the bus-A select and register/memory strobes.
module bus_a_sequencer
  import bus_a_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic [2:0] busa_sel,
  output logic       ld_ac,
  output logic       ld_ar,
  output logic       ld_pc,
  output logic       ld_dr,
  output logic       ld_tr,
  output logic       inc_pc,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       fault
);

  if (DATA_W < 4 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_param_check
    $error("bus_a_sequencer: DATA_W must be >= 4 and MEM_TIMEOUT within 1..255");
  end

  state_e     state_q, state_d;
  logic [3:0] op_q;
  ctrl_t      ctrl_q;
  logic       wait_active;
  logic       timeout;

  assign wait_active = (state_q == StF2) || (state_q == StMr) || (state_q == StMw);

  bus_a_sequencer_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .active_i    (wait_active),
    .mem_ready_i (mem_ready),
    .timeout_o   (timeout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StF1;
      StF1:   state_d = StF2;
      StF2: begin
        if (mem_ready)    state_d = StDec;
        else if (timeout) state_d = StFault;
      end
      StDec: begin
        case (opcode)
          OP_NOP:                  state_d = StF1;
          OP_LDAC, OP_STAC, OP_ADD: state_d = StAdr;
          OP_JMP:                  state_d = StJmp;
          OP_MOVT:                 state_d = StMvt;
          OP_HALT:                 state_d = StEnd;
          default:                 state_d = StFault;
        endcase
      end
      StAdr:  state_d = (op_q == OP_STAC) ? StMw : StMr;
      StMr: begin
        if (mem_ready)    state_d = StEx;
        else if (timeout) state_d = StFault;
      end
      StEx:   state_d = StF1;
      StMw: begin
        if (mem_ready)    state_d = StF1;
        else if (timeout) state_d = StFault;
      end
      StJmp, StMvt:    state_d = StF1;
      StEnd, StFault:  state_d = state_q;
      default:         state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      ctrl_q  <= decode_ctrl(StIdle, 4'h0);
    end else begin
      state_q <= state_d;
      if (state_q == StDec) op_q <= opcode;
      ctrl_q  <= decode_ctrl(state_d, op_q);
    end
  end

  assign busa_sel = ctrl_q.sel;
  assign ld_ac    = ctrl_q.ld_ac;
  assign ld_ar    = ctrl_q.ld_ar;
  assign ld_pc    = ctrl_q.ld_pc;
  assign ld_tr    = ctrl_q.ld_tr;
  assign mem_rd   = ctrl_q.mem_rd;
  assign mem_wr   = ctrl_q.mem_wr;
  assign alu_op   = ctrl_q.alu_op;
  assign halted   = ctrl_q.halted;
  assign fault    = ctrl_q.fault;
  assign ld_dr    = mem_ready && ((state_q == StF2) || (state_q == StMr));
  assign inc_pc   = mem_ready && (state_q == StF2);

endmodule
